// File: rtl/delay_timer_pkg.sv
// Shared unit codes, channel FSM states and unit-length helper for the
// multi-channel valve delay timer.
package delay_timer_pkg;

    localparam logic [2:0] UNIT_TICK = 3'b001;
    localparam logic [2:0] UNIT_SEC  = 3'b010;
    localparam logic [2:0] UNIT_MIN  = 3'b011;
    localparam logic [2:0] UNIT_HOUR = 3'b100;
    localparam logic [2:0] UNIT_DAY  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAIN = 2'd1,
        TAIL = 2'd2,
        FIRE = 2'd3
    } state_t;

    // Ticks per unit for a given tick rate; 0 marks an invalid unit code.
    function automatic int unsigned unit_len(input logic [2:0] code, input int unsigned t);
        case (code)
            UNIT_TICK: return 1;
            UNIT_SEC:  return t;
            UNIT_MIN:  return 60 * t;
            UNIT_HOUR: return 3600 * t;
            UNIT_DAY:  return 86400 * t;
            default:   return 0;
        endcase
    endfunction

endpackage

// File: rtl/delay_timer_if.sv
// Control/status bundle for multi_channel_delay_timer; per-channel fields
// are packed side by side, channel i in the i-th slice.
interface delay_timer_if #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DELAY_W = 10
);
    logic [NUM_CH-1:0]         start;
    logic [NUM_CH-1:0]         abort;
    logic [NUM_CH*DELAY_W-1:0] delay;
    logic [NUM_CH*3-1:0]       delay_unit;
    logic [NUM_CH-1:0]         extra_en;
    logic [NUM_CH*DELAY_W-1:0] extra_ticks;
    logic [NUM_CH-1:0]         busy;
    logic [NUM_CH-1:0]         done;
    logic [NUM_CH-1:0]         unit_err;

    modport master (
        output start, abort, delay, delay_unit, extra_en, extra_ticks,
        input  busy, done, unit_err
    );

    modport slave (
        input  start, abort, delay, delay_unit, extra_en, extra_ticks,
        output busy, done, unit_err
    );
endinterface

// File: rtl/delay_timer_channel.sv
// One delay-timer channel: FSM, prescaler, unit counter and tick-resolution
// tail counter, all registered on clk_50Hz.
module delay_timer_channel
    import delay_timer_pkg::*;
#(
    parameter int unsigned DELAY_W       = 10,
    parameter int unsigned TICKS_PER_SEC = 50
) (
    input  logic               clk_50Hz,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [DELAY_W-1:0] delay,
    input  logic [2:0]         delay_unit,
    input  logic               extra_en,
    input  logic [DELAY_W-1:0] extra_ticks,
    output logic               busy,
    output logic               done,
    output logic               unit_err
);
    localparam int unsigned PRESC_W = $clog2(86400 * TICKS_PER_SEC);

    state_t               state;
    logic [PRESC_W-1:0]   presc;
    logic [PRESC_W-1:0]   held_len_m1;
    logic [DELAY_W-1:0]   unit_cnt;
    logic [DELAY_W-1:0]   tail_cnt;
    logic [DELAY_W-1:0]   held_delay;
    logic [DELAY_W-1:0]   held_tail;
    logic [DELAY_W-1:0]   unit_nxt;
    logic [DELAY_W-1:0]   tail_nxt;
    logic                 wrap;
    logic                 tail_req;
    int unsigned          len;

    always_comb begin
        len      = unit_len(delay_unit, TICKS_PER_SEC);
        wrap     = (presc == held_len_m1);
        unit_nxt = unit_cnt + DELAY_W'(1);
        tail_nxt = tail_cnt + DELAY_W'(1);
        tail_req = extra_en && (extra_ticks != '0);
    end

    // Counters compare their next value so the transition lands on the same
    // edge the count is reached; a zero delay with a tail skips MAIN entirely.
    always_ff @(posedge clk_50Hz) begin
        if (rst) begin
            state       <= IDLE;
            presc       <= '0;
            held_len_m1 <= '0;
            unit_cnt    <= '0;
            tail_cnt    <= '0;
            held_delay  <= '0;
            held_tail   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            unit_err    <= 1'b0;
        end else begin
            done     <= 1'b0;
            unit_err <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (start && len != 0) begin
                held_delay  <= delay;
                held_len_m1 <= PRESC_W'(len - 1);
                held_tail   <= extra_en ? extra_ticks : '0;
                presc       <= '0;
                unit_cnt    <= '0;
                tail_cnt    <= '0;
                busy        <= 1'b1;
                state       <= (delay == '0 && tail_req) ? TAIL : MAIN;
            end else begin
                unit_err <= start;
                case (state)
                    MAIN: begin
                        if (held_delay == '0 || (wrap && unit_nxt == held_delay)) begin
                            if (held_tail != '0) begin
                                state <= TAIL;
                            end else begin
                                state <= FIRE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else if (wrap) begin
                            presc    <= '0;
                            unit_cnt <= unit_nxt;
                        end else begin
                            presc <= presc + PRESC_W'(1);
                        end
                    end
                    TAIL: begin
                        if (tail_nxt == held_tail) begin
                            state <= FIRE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            tail_cnt <= tail_nxt;
                        end
                    end
                    FIRE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/multi_channel_delay_timer.sv
// N independent valve delay timers on the 50 Hz timebase; each channel is a
// delay_timer_channel fed from its slice of the interface buses.
module multi_channel_delay_timer #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned DELAY_W       = 10,
    parameter int unsigned TICKS_PER_SEC = 50
) (
    input  logic           clk_50Hz,
    input  logic           rst,
    delay_timer_if.slave   bus
);
    logic [NUM_CH-1:0] busy_v;
    logic [NUM_CH-1:0] done_v;
    logic [NUM_CH-1:0] err_v;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        delay_timer_channel #(
            .DELAY_W       (DELAY_W),
            .TICKS_PER_SEC (TICKS_PER_SEC)
        ) u_ch (
            .clk_50Hz    (clk_50Hz),
            .rst         (rst),
            .start       (bus.start[i]),
            .abort       (bus.abort[i]),
            .delay       (bus.delay[i*DELAY_W +: DELAY_W]),
            .delay_unit  (bus.delay_unit[i*3 +: 3]),
            .extra_en    (bus.extra_en[i]),
            .extra_ticks (bus.extra_ticks[i*DELAY_W +: DELAY_W]),
            .busy        (busy_v[i]),
            .done        (done_v[i]),
            .unit_err    (err_v[i])
        );
    end

    assign bus.busy     = busy_v;
    assign bus.done     = done_v;
    assign bus.unit_err = err_v;

endmodule

// File: tb/tb_multi_channel_delay_timer.sv
// Directed bench for multi_channel_delay_timer (T=2): per-edge busy/done/unit_err
// windows are set by hand for each scenario and checked every cycle.
module tb_multi_channel_delay_timer;
    import delay_timer_pkg::*;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DW     = 10;
    localparam int unsigned T      = 2;

    logic clk_50Hz;
    logic rst;

    delay_timer_if #(.NUM_CH(NUM_CH), .DELAY_W(DW)) bus ();

    multi_channel_delay_timer #(
        .NUM_CH        (NUM_CH),
        .DELAY_W       (DW),
        .TICKS_PER_SEC (T)
    ) dut (
        .clk_50Hz (clk_50Hz),
        .rst      (rst),
        .bus      (bus.slave)
    );

    initial clk_50Hz = 1'b0;
    always #5 clk_50Hz = ~clk_50Hz;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_no;
    int b_from [NUM_CH];
    int b_to   [NUM_CH];
    int d_at   [NUM_CH];
    int ue_at  [NUM_CH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic new_test();
        edge_no = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            b_from[c] = 0;
            b_to[c]   = 0;
            d_at[c]   = -1;
            ue_at[c]  = -1;
        end
    endtask

    task automatic exp_ch(input int c, input int from, input int to, input int d);
        b_from[c] = from;
        b_to[c]   = to;
        d_at[c]   = d;
    endtask

    task automatic prog(input int c, input int d, input logic [2:0] u, input logic xe, input int xt);
        bus.delay[c*DW +: DW]       = DW'(d);
        bus.delay_unit[c*3 +: 3]    = u;
        bus.extra_en[c]             = xe;
        bus.extra_ticks[c*DW +: DW] = DW'(xt);
    endtask

    // Advance n edges; after each, compare outputs with the expected windows
    // and drop the one-cycle strobes and rst.
    task automatic watch(input int n);
        logic [NUM_CH-1:0] eb, ed, eu;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_50Hz);
            @(negedge clk_50Hz);
            for (int c = 0; c < NUM_CH; c++) begin
                eb[c] = (edge_no >= b_from[c]) && (edge_no < b_to[c]);
                ed[c] = (edge_no == d_at[c]);
                eu[c] = (edge_no == ue_at[c]);
            end
            check_eq($sformatf("busy@%0d", edge_no), 32'(bus.busy), 32'(eb));
            check_eq($sformatf("done@%0d", edge_no), 32'(bus.done), 32'(ed));
            check_eq($sformatf("unit_err@%0d", edge_no), 32'(bus.unit_err), 32'(eu));
            bus.start = '0;
            bus.abort = '0;
            rst       = 1'b0;
            edge_no++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start       = '0;
        bus.abort       = '0;
        bus.delay       = '0;
        bus.delay_unit  = '0;
        bus.extra_en    = '0;
        bus.extra_ticks = '0;
        rst             = 1'b1;
        @(negedge clk_50Hz);

        // reset state
        new_test();
        rst = 1'b1;
        watch(1);
        rst = 1'b1;
        watch(2);

        // seconds, start at edge 10, D=6; inputs scrambled after start
        new_test();
        watch(10);
        prog(0, 3, UNIT_SEC, 1'b0, 0);
        bus.start[0] = 1'b1;
        exp_ch(0, 10, 16, 16);
        watch(1);
        prog(0, 0, UNIT_DAY, 1'b1, 7);
        watch(11);

        // tick units with tails, zero-delay boundaries
        new_test();
        prog(1, 2, UNIT_TICK, 1'b1, 5);
        prog(2, 0, UNIT_TICK, 1'b0, 9);
        prog(0, 0, UNIT_TICK, 1'b1, 3);
        prog(3, 1, UNIT_TICK, 1'b1, 0);
        bus.start = '1;
        exp_ch(1, 0, 7, 7);
        exp_ch(2, 0, 1, 1);
        exp_ch(0, 0, 3, 3);
        exp_ch(3, 0, 1, 1);
        watch(10);

        // invalid units, including one aimed at a running channel
        new_test();
        prog(0, 1, 3'b110, 1'b0, 0);
        prog(1, 1, 3'b000, 1'b0, 0);
        prog(2, 2, UNIT_SEC, 1'b0, 0);
        bus.start = 4'b0111;
        ue_at[0] = 0;
        ue_at[1] = 0;
        exp_ch(2, 0, 4, 4);
        watch(1);
        prog(2, 1, 3'b111, 1'b0, 0);
        bus.start[2] = 1'b1;
        ue_at[2] = 1;
        watch(6);

        // abort mid-run, abort on idle channel, start+abort together
        new_test();
        prog(3, 4, UNIT_SEC, 1'b0, 0);
        bus.start[3] = 1'b1;
        exp_ch(3, 0, 5, -1);
        watch(5);
        bus.abort = 4'b1001;
        watch(15);
        bus.start[3] = 1'b1;
        bus.abort[3] = 1'b1;
        watch(5);

        // retrigger references the new start
        new_test();
        prog(0, 5, UNIT_SEC, 1'b0, 0);
        bus.start[0] = 1'b1;
        exp_ch(0, 0, 8, 8);
        watch(6);
        prog(0, 1, UNIT_SEC, 1'b0, 0);
        bus.start[0] = 1'b1;
        watch(8);

        // rst mid-run discards timing
        new_test();
        prog(1, 3, UNIT_SEC, 1'b0, 0);
        bus.start[1] = 1'b1;
        exp_ch(1, 0, 4, -1);
        watch(4);
        rst = 1'b1;
        watch(10);

        // all channels concurrently, 1..4 s
        new_test();
        for (int c = 0; c < NUM_CH; c++) begin
            prog(c, c + 1, UNIT_SEC, 1'b0, 0);
            exp_ch(c, 0, 2 * (c + 1), 2 * (c + 1));
        end
        bus.start = '1;
        watch(12);

        // long units: hour 7200, 2 min 240, day run aborted at edge 100
        new_test();
        prog(2, 1, UNIT_HOUR, 1'b0, 0);
        prog(1, 2, UNIT_MIN, 1'b0, 0);
        prog(0, 1, UNIT_DAY, 1'b0, 0);
        bus.start = 4'b0111;
        exp_ch(2, 0, 7200, 7200);
        exp_ch(1, 0, 240, 240);
        exp_ch(0, 0, 100, -1);
        watch(100);
        bus.abort[0] = 1'b1;
        watch(7110);

        // unit length table
        check_eq("len_day_T2", unit_len(UNIT_DAY, 2), 32'd172800);
        check_eq("len_hour_T50", unit_len(UNIT_HOUR, 50), 32'd180000);
        check_eq("len_min_T50", unit_len(UNIT_MIN, 50), 32'd3000);
        check_eq("len_tick", unit_len(UNIT_TICK, 50), 32'd1);
        check_eq("len_invalid", unit_len(3'b110, 50), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_channel_delay_timer.md
# multi_channel_delay_timer

Parametrised N-channel delay timer for valve sequencing, running directly from the 50 Hz timebase. Each channel independently times a programmed delay in ticks, seconds, minutes, hours or days, with an optional extra tick-resolution tail for debug. It signals completion with a one-cycle pulse. It replaces the single-channel delay counter in the valve-control path so that several valves can be timed concurrently from one block.

## Interface
- NUM_CH, 4, number of independent timer channels (1..16)
- DELAY_W, 10, width of each delay and extra_ticks field
- TICKS_PER_SEC, 50, clk_50Hz cycles per second; reduced in simulation only
- clk_50Hz  in  1  timebase clock; all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  NUM_CH  per-channel start strobe, sampled each edge
- abort  in  NUM_CH  per-channel cancel strobe
- delay  in  NUM_CH*DELAY_W  delay count in the selected unit; channel i at [i*DELAY_W +: DELAY_W]
- delay_unit  in  NUM_CH*3  unit code per channel: 001 tick (20 ms), 010 s, 011 min, 100 h, 101 day
- extra_en  in  NUM_CH  appends extra_ticks after the main delay
- extra_ticks  in  NUM_CH*DELAY_W  tail length in ticks
- busy  out  NUM_CH  channel is timing
- done  out  NUM_CH  one-cycle completion pulse
- unit_err  out  NUM_CH  one-cycle pulse when start is rejected for an invalid unit

## Operation
- Per-channel FSM states:
  - IDLE: busy=0.
  - MAIN: counts units up to the latched delay.
  - TAIL: counts ticks up to the latched extra_ticks.
  - FIRE: one cycle, done=1, then IDLE.
- Latching on start: delay, unit, extra_en and extra_ticks are latched when start is accepted. Later input changes do not affect a running channel.
- Unit lengths in ticks (shared constants): 1, T, 60T, 3600T, 86400T, where T = TICKS_PER_SEC.
- Prescaler: counts 0..unit_len-1. Each wrap increments the unit counter.
- MAIN → TAIL or FIRE: when unit counter == delay, go to TAIL if extra_en and extra_ticks != 0, otherwise FIRE.
- TAIL → FIRE: when the tail counter reaches extra_ticks.
- Invalid unit (000, 110, 111) on start: start is ignored, unit_err pulses, state is unchanged.
- Start while busy: retriggers. Counters clear and new values are latched.
- Abort: returns the channel to IDLE with no done pulse.
  - abort and start in the same cycle: abort wins.
  - abort while IDLE: no effect.
- delay=0 with no tail: MAIN lasts zero units. FIRE occurs on the edge after start.
- Channels are fully independent. There is no cross-channel arbitration or ordering.
- rst: every channel goes to IDLE and all counters clear. Reset values: busy=0, done=0, unit_err=0. rst mid-run discards the timing with no done pulse.

## Timing
- Start accepted at edge k. Let D = delay×unit_len + (extra_en ? extra_ticks : 0).
  - busy=1 from edge k through edge k+max(D,1).
  - done=1 for exactly the cycle after edge k+max(D,1); busy=0 in that cycle.
- Retrigger at edge j: the next done is referenced to j, not to the original start.
- Outputs are registered. There is no combinational path from inputs to outputs.
- Counter widths:
  - prescaler: clog2(86400·T) bits (23 for T=50)
  - unit and tail counters: DELAY_W bits
  - Comparisons are equality against latched values, so the counters never wrap.
- The maximum day delay (1023 days) is reachable with no overflow.

## Structure
- Package delay_timer_pkg holds:
  - unit code localparams: UNIT_TICK, UNIT_SEC, UNIT_MIN, UNIT_HOUR, UNIT_DAY
  - FSM state encoding: IDLE, MAIN, TAIL, FIRE
  - function unit_len(code, T) returning ticks per unit, 0 for invalid codes
- Sub-module delay_timer_channel implements one channel: FSM, prescaler, unit counter and tail counter.
- The top level generate-instantiates NUM_CH copies of delay_timer_channel and slices the buses.

## Test plan
- T=2, ch0 delay=3 unit=010, start at edge 10 → ch0 busy edges 10..16, done pulse in the cycle after edge 16 (D=6); other channels stay idle.
- T=50, ch1 delay=2 unit=001 extra_en=1 extra_ticks=5, start at edge 0 → done after edge 7; ch2 delay=0 with the same start → done after edge 1.
- ch0 unit=110 start → unit_err pulse for one cycle, busy stays 0, no done.
- T=2, ch3 delay=4 unit=010, start at 0, abort at edge 5 → busy drops after edge 5, no done ever; start+abort together at edge 20 → remains IDLE.
- T=2, ch0 delay=5 unit=010 started at 0, retrigger at edge 6 with delay=1 → done after edge 8 only; rst at edge 4 of a fresh run → all outputs 0, no done.
- T=2, all channels started on the same edge with delays 1..4 s → done pulses after edges 2, 4, 6, 8 respectively; one day-unit run (delay=1) completes at 172800 ticks.
